keypad_buffer: RTL and testbench

- Downstream consumer of the keypad driver output. It sits between the keypad driver and the RAT CPU I/O bus.
- Captures each key code on the rising edge of the driver's key-strobe and queues it in a small FIFO, so keystrokes are not lost while the CPU is busy.
- Exposes a data port and a status port on the CPU IN bus, and raises a fixed-length interrupt pulse to the CPU for every accepted key.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_fifo_core.sv | 66 ++++++
 rtl/keypad_buffer.sv | 100 ++++++++++
 tb/tb_keypad_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad buffer: default I/O port addresses and the
// status-byte layout, plus a helper that packs the status byte.
package keypad_pkg;

  localparam logic [7:0] DATA_PORT_DEF   = 8'h24;
  localparam logic [7:0] STATUS_PORT_DEF = 8'h25;

  localparam int ST_OVF     = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_CNT_MSB = 4;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic [4:0] cnt);
    logic [7:0] s;
    s                 = '0;
    s[ST_OVF]         = ovf;
    s[ST_FULL]        = full;
    s[ST_EMPTY]       = empty;
    s[ST_CNT_MSB:0]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/key_fifo_core.sv
// Generic synchronous FIFO with combinational head read. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module key_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_q;

  // Distributed storage: the head must be readable in the same cycle.
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/keypad_buffer.sv
// Keypad-to-CPU bridge: queues one key per key_strobe rising edge, exposes
// data/status ports on the CPU IN bus and pulses int_out per accepted key.
module keypad_buffer
  import keypad_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] DATA_PORT   = DATA_PORT_DEF,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF,
  parameter int         INT_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_strobe,
  input  logic [7:0]             key_data,
  input  logic [7:0]             port_id,
  input  logic                   rd_strb,
  output logic [7:0]             rd_data,
  output logic                   int_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(INT_CYCLES + 1);

  logic          key_strobe_q;
  logic          armed_q;
  logic          push_q;
  logic [7:0]    push_data_q;
  logic          overflow_q, overflow_d;
  logic [IW-1:0] int_cnt_q, int_cnt_d;

  logic          push_req, data_rd, status_rd, overflow_set;
  logic [7:0]    head;
  logic          full, empty, push_ok;
  logic [CW-1:0] fifo_count;

  // armed_q keeps a strobe that is held high across reset from counting as an edge.
  assign push_req  = key_strobe & ~key_strobe_q & armed_q;
  assign data_rd   = rd_strb & (port_id == DATA_PORT);
  assign status_rd = rd_strb & (port_id == STATUS_PORT);

  key_fifo_core #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_q),
    .pop     (data_rd),
    .wr_data (push_data_q),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count),
    .push_ok (push_ok)
  );

  // A refused push can only mean full with no same-cycle pop.
  assign overflow_set = push_q & ~push_ok;

  always_comb begin
    overflow_d = overflow_q;
    if (status_rd)    overflow_d = 1'b0;
    if (overflow_set) overflow_d = 1'b1;

    int_cnt_d = int_cnt_q;
    if (push_ok)                int_cnt_d = IW'(INT_CYCLES);
    else if (int_cnt_q != '0)   int_cnt_d = int_cnt_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_strobe_q <= 1'b0;
      armed_q      <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= 8'h00;
      overflow_q   <= 1'b0;
      int_cnt_q    <= '0;
    end else begin
      key_strobe_q <= key_strobe;
      armed_q      <= armed_q | ~key_strobe;
      push_q       <= push_req;
      push_data_q  <= key_data;
      overflow_q   <= overflow_d;
      int_cnt_q    <= int_cnt_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (port_id == DATA_PORT)
      rd_data = empty ? 8'h00 : head;
    else if (port_id == STATUS_PORT)
      rd_data = status_byte(overflow_q, full, empty, 5'(fifo_count));
  end

  assign int_out = (int_cnt_q != '0);
  assign count   = fifo_count;

endmodule

// File: tb/tb_keypad_buffer.sv
// Self-checking bench for keypad_buffer: hand-derived vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_keypad_buffer;

  localparam int         DEPTH      = 8;
  localparam int         INT_CYCLES = 4;
  localparam logic [7:0] DP         = 8'h24;
  localparam logic [7:0] SP         = 8'h25;

  logic       clk = 1'b0;
  logic       reset, key_strobe, rd_strb;
  logic [7:0] key_data, port_id, rd_data;
  logic       int_out;
  logic [3:0] count;

  always #5 clk = ~clk;

  keypad_buffer #(
    .DEPTH       (DEPTH),
    .DATA_PORT   (DP),
    .STATUS_PORT (SP),
    .INT_CYCLES  (INT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_strobe (key_strobe),
    .key_data   (key_data),
    .port_id    (port_id),
    .rd_strb    (rd_strb),
    .rd_data    (rd_data),
    .int_out    (int_out),
    .count      (count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted keys, sticky overflow, pulse cycles left,
  // and a one-cycle pending key between strobe rise and the FIFO write.
  byte unsigned mq[$];
  bit           m_ovf, m_prev, m_armed, m_pend, m_valid;
  byte unsigned m_pend_data;
  int           m_int;

  logic [7:0] last_rd;
  logic [3:0] last_cnt;
  logic       last_int;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] pid);
    if (pid == DP) return (mq.size() != 0) ? 8'(mq[0]) : 8'h00;
    if (pid == SP) return {m_ovf, mq.size() == DEPTH, mq.size() == 0, 5'(mq.size())};
    return 8'h00;
  endfunction

  task automatic model_step(input bit rst, input bit s, input logic [7:0] d,
                            input logic [7:0] pid, input bit rd);
    bit pop, acc;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_prev = 0; m_armed = 0; m_pend = 0; m_int = 0; m_valid = 1;
      return;
    end
    pop = rd && (pid == DP) && (mq.size() > 0);
    acc = m_pend && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(m_pend_data);
    if (m_pend && !acc)        m_ovf = 1;
    else if (rd && (pid == SP)) m_ovf = 0;
    m_int = acc ? INT_CYCLES : ((m_int > 0) ? m_int - 1 : 0);
    m_pend      = s && !m_prev && m_armed;
    m_pend_data = d;
    m_prev      = s;
    if (!s) m_armed = 1;
  endtask

  // One clock cycle: drive at negedge, sample/compare 1ns later, advance model at posedge.
  task automatic cycle(input bit rst, input bit s, input logic [7:0] d,
                       input logic [7:0] pid, input bit rd);
    reset = rst; key_strobe = s; key_data = d; port_id = pid; rd_strb = rd;
    #1;
    last_rd  = rd_data;
    last_cnt = count;
    last_int = int_out;
    if (m_valid) begin
      check("model rd_data", rd_data, exp_rd(pid));
      check("model count", 8'(count), 8'(mq.size()));
      check("model int_out", 8'(int_out), 8'(m_int != 0));
    end
    @(posedge clk);
    model_step(rst, s, d, pid, rd);
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] d);
    cycle(0, 1, d, 8'h30, 0);
    cycle(0, 0, d, 8'h30, 0);
    $display("press key=%02h count=%0d int_out=%0b", d, count, int_out);
  endtask

  task automatic read_port(input logic [7:0] pid, input bit rd, output logic [7:0] v);
    cycle(0, 0, 8'h00, pid, rd);
    v = last_rd;
    $display("%s port=%02h data=%02h count=%0d", rd ? "read" : "peek", pid, v, count);
  endtask

  typedef struct {
    bit         rst, s;
    logic [7:0] d, pid;
    bit         rd, chk;
    logic [7:0] e_rd;
    logic [3:0] e_cnt;
    bit         e_int;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] v;

  initial begin
    m_valid = 0;
    reset = 1; key_strobe = 0; key_data = 0; port_id = 0; rd_strb = 0;

    // Single 5-cycle strobe of key 07: push lands 2 cycles after the rise, 4-cycle pulse.
    tbl[0]  = '{1, 0, 8'h00, SP, 0, 0, 8'h00, 4'd0, 0};
    tbl[1]  = '{0, 0, 8'h00, SP, 0, 1, 8'h20, 4'd0, 0};
    tbl[2]  = '{0, 1, 8'h07, DP, 0, 1, 8'h00, 4'd0, 0};
    tbl[3]  = '{0, 1, 8'h07, DP, 0, 1, 8'h00, 4'd0, 0};
    tbl[4]  = '{0, 1, 8'h07, DP, 0, 1, 8'h07, 4'd1, 1};
    tbl[5]  = '{0, 1, 8'h07, DP, 0, 1, 8'h07, 4'd1, 1};
    tbl[6]  = '{0, 1, 8'h07, DP, 0, 1, 8'h07, 4'd1, 1};
    tbl[7]  = '{0, 0, 8'h07, DP, 0, 1, 8'h07, 4'd1, 1};
    tbl[8]  = '{0, 0, 8'h07, DP, 0, 1, 8'h07, 4'd1, 0};
    tbl[9]  = '{0, 0, 8'h00, DP, 1, 1, 8'h07, 4'd1, 0};
    tbl[10] = '{0, 0, 8'h00, SP, 0, 1, 8'h20, 4'd0, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst, tbl[i].s, tbl[i].d, tbl[i].pid, tbl[i].rd);
      $display("vec %0d rd_data=%02h count=%0d int_out=%0b", i, last_rd, last_cnt, last_int);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d rd_data", i), last_rd, tbl[i].e_rd);
        check($sformatf("vec%0d count", i), 8'(last_cnt), 8'(tbl[i].e_cnt));
        check($sformatf("vec%0d int_out", i), 8'(last_int), 8'(tbl[i].e_int));
      end
    end

    // In-order delivery of three keys.
    press(8'h01); press(8'h02); press(8'h03);
    check("fifo3 count", 8'(count), 8'd3);
    read_port(DP, 1, v); check("fifo3 first", v, 8'h01);
    read_port(DP, 1, v); check("fifo3 second", v, 8'h02);
    read_port(DP, 1, v); check("fifo3 third", v, 8'h03);
    read_port(SP, 0, v); check("fifo3 status empty", v, 8'h20);

    // Nine keys into eight slots: ninth dropped, sticky overflow cleared by a status read.
    for (int i = 0; i < 9; i++) press(8'h10 + 8'(i));
    read_port(SP, 0, v); check("ovf status peek", v, 8'hC8);
    read_port(SP, 1, v); check("ovf status read1", v, 8'hC8);
    read_port(SP, 1, v); check("ovf status read2", v, 8'h48);

    // Full FIFO: push coinciding with a data read is accepted without overflow.
    cycle(0, 1, 8'h0A, 8'h30, 0);
    cycle(0, 0, 8'h0A, DP, 1);
    $display("push+read key=0a data=%02h count=%0d", last_rd, count);
    check("full pushpop head", last_rd, 8'h10);
    check("full pushpop count", 8'(count), 8'd8);
    read_port(SP, 0, v); check("full pushpop status", v, 8'h48);
    for (int i = 0; i < 7; i++) begin
      read_port(DP, 1, v); check("drain order", v, 8'h11 + 8'(i));
    end
    read_port(DP, 1, v); check("last entry", v, 8'h0A);

    // Empty reads and an unmapped port.
    read_port(DP, 1, v); check("empty data read", v, 8'h00);
    check("empty count", 8'(count), 8'd0);
    read_port(8'h30, 1, v); check("port30 read", v, 8'h00);
    read_port(SP, 0, v); check("empty status", v, 8'h20);

    // Reset with keys queued and the interrupt active.
    for (int i = 0; i < 4; i++) press(8'h20 + 8'(i));
    check("pre-reset int_out", 8'(int_out), 8'd1);
    check("pre-reset count", 8'(count), 8'd4);
    cycle(1, 0, 8'h00, SP, 0);
    read_port(SP, 0, v);
    check("post-reset status", v, 8'h20);
    check("post-reset count", 8'(last_cnt), 8'd0);
    check("post-reset int_out", 8'(last_int), 8'd0);

    // Strobe held high across reset release is not an edge.
    cycle(1, 1, 8'h55, SP, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h55, SP, 0);
    check("held strobe count", 8'(count), 8'd0);
    cycle(0, 0, 8'h55, SP, 0);
    press(8'h55);
    check("rearm count", 8'(count), 8'd1);
    read_port(DP, 1, v); check("rearm key", v, 8'h55);

    // Random traffic: light reads first (overflow-heavy), then heavy reads.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] pid;
      int         r;
      bit         rd;
      r   = $urandom_range(0, 3);
      pid = (r == 0) ? DP : (r == 1) ? SP : (r == 2) ? 8'h30 : 8'($urandom);
      rd  = (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, 8'($urandom), pid, rd);
    end
    $display("random phase done count=%0d", count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
